// File: rtl/adding_machine_pkg.sv
// Shared types and constants for the adding-machine controller:
// opcode encodings, FSM state type and the bundle of datapath strobes.
package adding_machine_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;

    // IR[7:6] opcode encodings.
    localparam logic [1:0] OP_LDA  = 2'b00;
    localparam logic [1:0] OP_STA  = 2'b01;
    localparam logic [1:0] OP_ADDI = 2'b10;
    localparam logic [1:0] OP_JMP  = 2'b11;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_FETCH,
        ST_DECODE,
        ST_LDA,
        ST_STA,
        ST_ADDI,
        ST_JMP,
        ST_ERROR
    } state_t;

    // Every strobe the controller drives, gathered so a whole output
    // pattern can be built, defaulted and compared as one value.
    typedef struct packed {
        logic mem_rd;
        logic mem_wr;
        logic load_ir;
        logic load_acc;
        logic sel_alu;
        logic sel_bus;
        logic pass_add;
        logic ld_pc;
        logic clr_pc;
        logic inc_pc;
        logic ir_on_adr;
        logic pc_on_adr;
        logic err;
    } ctrl_t;

endpackage

// File: rtl/adding_machine_controller_if.sv
// Controller <-> datapath/memory signal bundle. The controller side uses
// the master modport; the datapath and memory (or a bench) use slave.
interface adding_machine_controller_if;

    logic [1:0] ir_opcode;
    logic       mem_ready;
    logic       mem_rd;
    logic       mem_wr;
    logic       load_IR;
    logic       load_acc;
    logic       sel_alu;
    logic       sel_bus;
    logic       pass_add;
    logic       ld_pc;
    logic       clr_pc;
    logic       inc_pc;
    logic       ir_on_adr;
    logic       pc_on_adr;
    logic       err;

    modport master (
        input  ir_opcode, mem_ready,
        output mem_rd, mem_wr, load_IR, load_acc, sel_alu, sel_bus, pass_add,
               ld_pc, clr_pc, inc_pc, ir_on_adr, pc_on_adr, err
    );

    modport slave (
        output ir_opcode, mem_ready,
        input  mem_rd, mem_wr, load_IR, load_acc, sel_alu, sel_bus, pass_add,
               ld_pc, clr_pc, inc_pc, ir_on_adr, pc_on_adr, err
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Memory-wait watchdog counter. Counts cycles a request spends waiting and
// flags the wait cycle that would be the MEM_TIMEOUT-th one.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15  // 1..255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

    logic [7:0] count;

    // Only a cycle that is actually waiting can time out, so a mem_ready
    // arriving on the final allowed cycle still completes normally.
    assign timeout = enable && (count == LAST_WAIT);

    // Wait counter: clear has priority over counting.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values and simulation matches hardware.
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/adding_machine_controller.sv
// Fetch/decode/execute controller for the adding-machine datapath.
// Outputs decode combinationally from the state register plus mem_ready.
module adding_machine_controller
    import adding_machine_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15  // 1..255
) (
    input logic                        clock,
    input logic                        reset,
    adding_machine_controller_if.master bus
);

    state_t state;
    state_t state_next;
    ctrl_t  ctrl;
    logic   waiting;
    logic   timeout;
    logic   wd_clear;

    // A request is outstanding only in the three memory-access states.
    assign waiting  = (state inside {ST_FETCH, ST_LDA, ST_STA}) && !bus.mem_ready;
    // Any state change restarts the watchdog, which covers every entry
    // into FETCH, LDA and STA.
    assign wd_clear = (state_next != state);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (waiting),
        .timeout (timeout)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; the opcode is only looked at in DECODE.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_INIT:   state_next = ST_FETCH;
            ST_FETCH: begin
                if (bus.mem_ready)  state_next = ST_DECODE;
                else if (timeout)   state_next = ST_ERROR;
            end
            ST_DECODE: begin
                unique case (bus.ir_opcode)
                    OP_LDA:  state_next = ST_LDA;
                    OP_STA:  state_next = ST_STA;
                    OP_ADDI: state_next = ST_ADDI;
                    OP_JMP:  state_next = ST_JMP;
                    default: state_next = ST_ERROR;
                endcase
            end
            ST_LDA, ST_STA: begin
                if (bus.mem_ready)  state_next = ST_FETCH;
                else if (timeout)   state_next = ST_ERROR;
            end
            ST_ADDI:   state_next = ST_FETCH;
            ST_JMP:    state_next = ST_FETCH;
            ST_ERROR:  state_next = ST_ERROR;
            default:   state_next = ST_ERROR;
        endcase
    end

    // Output decode per state; mem_ready only gates the completion strobes.
    always_comb begin
        // NOTE: defaulting the whole struct first guarantees every strobe is
        // assigned on every path, so no latch can be inferred.
        ctrl = '0;
        unique case (state)
            ST_INIT: ctrl.clr_pc = 1'b1;
            ST_FETCH: begin
                ctrl.pc_on_adr = 1'b1;
                ctrl.mem_rd    = 1'b1;
                ctrl.load_ir   = bus.mem_ready;
                ctrl.inc_pc    = bus.mem_ready;
            end
            ST_DECODE: ctrl = '0;
            ST_LDA: begin
                ctrl.ir_on_adr = 1'b1;
                ctrl.mem_rd    = 1'b1;
                ctrl.sel_bus   = 1'b1;
                ctrl.load_acc  = bus.mem_ready;
            end
            ST_STA: begin
                ctrl.ir_on_adr = 1'b1;
                ctrl.mem_wr    = 1'b1;
            end
            ST_ADDI: begin
                ctrl.sel_alu   = 1'b1;
                ctrl.pass_add  = 1'b1;
                ctrl.load_acc  = 1'b1;
            end
            ST_JMP:   ctrl.ld_pc = 1'b1;
            ST_ERROR: ctrl.err   = 1'b1;
            default:  ctrl = '0;
        endcase
    end

    assign bus.mem_rd    = ctrl.mem_rd;
    assign bus.mem_wr    = ctrl.mem_wr;
    assign bus.load_IR   = ctrl.load_ir;
    assign bus.load_acc  = ctrl.load_acc;
    assign bus.sel_alu   = ctrl.sel_alu;
    assign bus.sel_bus   = ctrl.sel_bus;
    assign bus.pass_add  = ctrl.pass_add;
    assign bus.ld_pc     = ctrl.ld_pc;
    assign bus.clr_pc    = ctrl.clr_pc;
    assign bus.inc_pc    = ctrl.inc_pc;
    assign bus.ir_on_adr = ctrl.ir_on_adr;
    assign bus.pc_on_adr = ctrl.pc_on_adr;
    assign bus.err       = ctrl.err;

endmodule

// File: tb/tb_adding_machine_controller.sv
// Bench for adding_machine_controller: a directed vector table, a few
// hand-written watchdog sequences, and random instruction streams checked
// against per-instruction expected strobe traces.
module tb_adding_machine_controller;
    import adding_machine_pkg::*;

    localparam int TO = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    adding_machine_controller_if bus_if ();

    adding_machine_controller #(
        .MEM_TIMEOUT(TO)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    ctrl_t act;
    assign act = {bus_if.mem_rd, bus_if.mem_wr, bus_if.load_IR, bus_if.load_acc,
                  bus_if.sel_alu, bus_if.sel_bus, bus_if.pass_add, bus_if.ld_pc,
                  bus_if.clr_pc, bus_if.inc_pc, bus_if.ir_on_adr, bus_if.pc_on_adr,
                  bus_if.err};

    int total  = 0;
    int passed = 0;

    // Expected strobe patterns for each phase of an instruction.
    function automatic ctrl_t v_init();
        ctrl_t c = '0;
        c.clr_pc = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t v_fetch(input bit rdy);
        ctrl_t c = '0;
        c.pc_on_adr = 1'b1;
        c.mem_rd    = 1'b1;
        c.load_ir   = rdy;
        c.inc_pc    = rdy;
        return c;
    endfunction

    function automatic ctrl_t v_decode();
        return '0;
    endfunction

    function automatic ctrl_t v_lda(input bit rdy);
        ctrl_t c = '0;
        c.ir_on_adr = 1'b1;
        c.mem_rd    = 1'b1;
        c.sel_bus   = 1'b1;
        c.load_acc  = rdy;
        return c;
    endfunction

    function automatic ctrl_t v_sta();
        ctrl_t c = '0;
        c.ir_on_adr = 1'b1;
        c.mem_wr    = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t v_addi();
        ctrl_t c = '0;
        c.sel_alu  = 1'b1;
        c.pass_add = 1'b1;
        c.load_acc = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t v_jmp();
        ctrl_t c = '0;
        c.ld_pc = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t v_error();
        ctrl_t c = '0;
        c.err = 1'b1;
        return c;
    endfunction

    function automatic logic [1:0] rand_op();
        return 2'($urandom_range(0, 3));
    endfunction

    function automatic bit rand_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock cycle: drive inputs just after the rising edge, compare
    // outputs on the falling edge.
    task automatic step(input bit rst, input bit rdy, input logic [1:0] op,
                        input ctrl_t exp, input string name);
        reset            = rst;
        bus_if.mem_ready = rdy;
        bus_if.ir_opcode = op;
        @(negedge clock);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, rand_bit(), rand_op(), v_init(), "rst_hold");
        step(1'b0, rand_bit(), rand_op(), v_init(), "rst_release_init");
    endtask

    // A request that never completes: TO wait cycles, then sticky ERROR
    // until reset.
    task automatic trap(input ctrl_t wait_v, input int err_cycles, input string name);
        for (int i = 0; i < TO; i++) step(1'b0, 1'b0, rand_op(), wait_v, name);
        for (int i = 0; i < err_cycles; i++)
            step(1'b0, rand_bit(), rand_op(), v_error(), "err_sticky");
        do_reset();
    endtask

    // Execute one full instruction with the given wait counts; a wait
    // count of TO or more means memory never answers.
    task automatic run_instr(input logic [1:0] op, input int wf, input int we);
        if (wf >= TO) begin
            trap(v_fetch(1'b0), 3, "rnd_fetch_hang");
            return;
        end
        for (int i = 0; i < wf; i++) step(1'b0, 1'b0, rand_op(), v_fetch(1'b0), "rnd_fetch_wait");
        step(1'b0, 1'b1, rand_op(), v_fetch(1'b1), "rnd_fetch_done");
        step(1'b0, rand_bit(), op, v_decode(), "rnd_decode");
        case (op)
            OP_ADDI: step(1'b0, rand_bit(), rand_op(), v_addi(), "rnd_addi");
            OP_JMP:  step(1'b0, rand_bit(), rand_op(), v_jmp(), "rnd_jmp");
            OP_LDA: begin
                if (we >= TO) trap(v_lda(1'b0), 3, "rnd_lda_hang");
                else begin
                    for (int i = 0; i < we; i++)
                        step(1'b0, 1'b0, rand_op(), v_lda(1'b0), "rnd_lda_wait");
                    step(1'b0, 1'b1, rand_op(), v_lda(1'b1), "rnd_lda_done");
                end
            end
            default: begin
                if (we >= TO) trap(v_sta(), 3, "rnd_sta_hang");
                else begin
                    for (int i = 0; i <= we; i++)
                        step(1'b0, (i == we), rand_op(), v_sta(), "rnd_sta");
                end
            end
        endcase
    endtask

    typedef struct {
        bit         rst;
        bit         rdy;
        logic [1:0] op;
        ctrl_t      exp;
        string      name;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit rst, input bit rdy, input logic [1:0] op,
                                input ctrl_t exp, input string name);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.op = op; v.exp = exp; v.name = name;
        tbl.push_back(v);
    endfunction

    initial begin
        bus_if.mem_ready = 1'b0;
        bus_if.ir_opcode = 2'b00;

        // Directed table: reset, ADDI, LDA with 3 waits, STA with 2 waits,
        // JMP, fetch finishing on the last allowed wait, reset mid-STA.
        add(1, 1, OP_ADDI, v_init(),       "reset_init");
        add(0, 1, OP_ADDI, v_init(),       "post_reset_init");
        add(0, 1, OP_ADDI, v_fetch(1'b1),  "addi_fetch");
        add(0, 1, OP_ADDI, v_decode(),     "addi_decode");
        add(0, 1, OP_ADDI, v_addi(),       "addi_exec");
        add(0, 1, OP_LDA,  v_fetch(1'b1),  "lda_fetch");
        add(0, 1, OP_LDA,  v_decode(),     "lda_decode");
        add(0, 0, OP_LDA,  v_lda(1'b0),    "lda_wait1");
        add(0, 0, OP_LDA,  v_lda(1'b0),    "lda_wait2");
        add(0, 0, OP_LDA,  v_lda(1'b0),    "lda_wait3");
        add(0, 1, OP_LDA,  v_lda(1'b1),    "lda_done");
        add(0, 1, OP_STA,  v_fetch(1'b1),  "sta_fetch");
        add(0, 1, OP_STA,  v_decode(),     "sta_decode");
        add(0, 0, OP_STA,  v_sta(),        "sta_wait1");
        add(0, 0, OP_STA,  v_sta(),        "sta_wait2");
        add(0, 1, OP_STA,  v_sta(),        "sta_done");
        add(0, 1, OP_JMP,  v_fetch(1'b1),  "jmp_fetch");
        add(0, 1, OP_JMP,  v_decode(),     "jmp_decode");
        add(0, 1, OP_JMP,  v_jmp(),        "jmp_exec");
        add(0, 0, OP_ADDI, v_fetch(1'b0),  "edge_fetch_wait1");
        add(0, 0, OP_ADDI, v_fetch(1'b0),  "edge_fetch_wait2");
        add(0, 0, OP_ADDI, v_fetch(1'b0),  "edge_fetch_wait3");
        add(0, 1, OP_ADDI, v_fetch(1'b1),  "edge_fetch_last_ok");
        add(0, 1, OP_ADDI, v_decode(),     "edge_decode");
        add(0, 1, OP_STA,  v_addi(),       "addi_ignores_ready");
        add(0, 1, OP_STA,  v_fetch(1'b1),  "sta2_fetch");
        add(0, 0, OP_STA,  v_decode(),     "sta2_decode");
        add(0, 0, OP_STA,  v_sta(),        "sta2_wait");
        add(1, 0, OP_STA,  v_init(),       "sta2_async_reset");
        add(0, 0, OP_STA,  v_init(),       "sta2_restart_init");
        add(0, 1, OP_STA,  v_fetch(1'b1),  "restart_fetch");
        add(0, 1, OP_STA,  v_decode(),     "restart_decode");
        add(0, 1, OP_STA,  v_sta(),        "restart_sta");

        foreach (tbl[i]) step(tbl[i].rst, tbl[i].rdy, tbl[i].op, tbl[i].exp, tbl[i].name);

        // Fetch hang: ERROR after the TO-th wait, held 20 cycles, cleared by reset.
        trap(v_fetch(1'b0), 20, "hang_fetch_wait");
        step(1'b0, 1'b1, OP_JMP, v_fetch(1'b1), "after_trap_fetch");
        step(1'b0, 1'b0, OP_JMP, v_decode(),    "after_trap_decode");
        step(1'b0, 1'b0, OP_ADDI, v_jmp(),      "after_trap_jmp");

        // STA hang, then LDA completing on its last allowed wait cycle.
        step(1'b0, 1'b1, OP_STA, v_fetch(1'b1), "hang_sta_fetch");
        step(1'b0, 1'b0, OP_STA, v_decode(),    "hang_sta_decode");
        trap(v_sta(), 2, "hang_sta_wait");
        run_instr(OP_LDA, 0, TO - 1);

        // Random instruction stream.
        for (int n = 0; n < 250; n++) begin
            int rf = $urandom_range(0, 15);
            int re = $urandom_range(0, 15);
            run_instr(rand_op(), (rf == 0) ? TO : rf % TO, (re == 0) ? TO : re % TO);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
